// File: rtl/fc_pkg.sv
// Shared types and helpers for the time-multiplexed fully connected layer.
// Holds the FSM state enum, address-width helpers and round/saturate.
package fc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    DRAIN,
    OUT,
    DONE
  } state_e;

  function automatic int n_groups(input int out_feat, input int lanes);
    return out_feat / lanes;
  endfunction

  // Address width that never collapses to zero bits.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Round half up at frac_w, then clamp to a signed data_w range.
  function automatic logic signed [63:0] sat_round(
    input logic signed [63:0] acc,
    input int                 frac_w,
    input int                 data_w
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output-neuron lane: bias load, signed MAC, rounded+saturated result.
// Ports: clk, rst, clr_i, en_i, bias_i, x_i, w_i, b_i -> y_o. Macro: FC_RELU_EN.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic                     bias_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] w_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] y_o
);

  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_x;
  logic signed [ACC_W-1:0]    bias_x;
  logic signed [DATA_W-1:0]   sat;

  assign prod   = x_i * w_i;
  assign prod_x = ACC_W'(prod);
  assign bias_x = ACC_W'(b_i) <<< FRAC_W;

  // The first return of a group replaces the old sum with bias + product.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = bias_i ? (bias_x + prod_x) : (acc_q + prod_x);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sat = DATA_W'(sat_round(64'(acc_q), FRAC_W, DATA_W));

`ifdef FC_RELU_EN
  assign y_o = sat[DATA_W-1] ? '0 : sat;
`else
  assign y_o = sat;
`endif

endmodule

// File: rtl/fc_layer_seq.sv
// Fully connected layer: buffers one feature vector, MACs LANES neurons per pass.
// Ports: start/busy/done, x valid/ready, w/b sync read, y valid/ready. Macro: FC_RELU_EN.
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int ACC_W    = 40,
  parameter int IN_FEAT  = 3,
  parameter int OUT_FEAT = 2,
  parameter int LANES    = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  output logic                                        busy,
  input  logic                                        x_valid,
  output logic                                        x_ready,
  input  logic [DATA_W-1:0]                           x_data,
  output logic                                        w_rd_en,
  output logic [addr_w(OUT_FEAT/LANES*IN_FEAT)-1:0]   w_addr,
  input  logic [LANES*DATA_W-1:0]                     w_rdata,
  output logic [addr_w(OUT_FEAT/LANES)-1:0]           b_addr,
  input  logic [LANES*DATA_W-1:0]                     b_rdata,
  output logic                                        y_valid,
  input  logic                                        y_ready,
  output logic [LANES*DATA_W-1:0]                     y_data,
  output logic [addr_w(OUT_FEAT/LANES)-1:0]           y_idx,
  output logic                                        done
);

  localparam int NG  = n_groups(OUT_FEAT, LANES);
  localparam int WAW = addr_w(NG * IN_FEAT);
  localparam int BAW = addr_w(NG);
  localparam int KW  = addr_w(IN_FEAT);

  if (ACC_W < 2 * DATA_W + $clog2(IN_FEAT)) begin : g_bad_acc
    $error("fc_layer_seq: ACC_W too narrow for IN_FEAT products");
  end
  if (OUT_FEAT % LANES != 0) begin : g_bad_lanes
    $error("fc_layer_seq: OUT_FEAT must be a multiple of LANES");
  end

  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [BAW-1:0]           g_q, g_d;
  logic signed [DATA_W-1:0] buf_q [IN_FEAT];
  logic                     rv_q;
  logic [KW-1:0]            rk_q;
  logic                     clr;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    g_d     = g_q;
    x_ready = 1'b0;
    w_rd_en = 1'b0;
    y_valid = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          k_d     = '0;
        end
      end
      LOAD: begin
        x_ready = 1'b1;
        if (x_valid) begin
          if (k_q == KW'(IN_FEAT - 1)) begin
            state_d = MAC;
            k_d     = '0;
            g_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      MAC: begin
        w_rd_en = 1'b1;
        if (k_q == KW'(IN_FEAT - 1)) begin
          state_d = DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
        y_valid = 1'b1;
        if (y_ready) begin
          if (g_q == BAW'(NG - 1)) begin
            state_d = DONE;
          end else begin
            g_d     = g_q + 1'b1;
            state_d = MAC;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      g_q     <= '0;
      rv_q    <= 1'b0;
      rk_q    <= '0;
      for (int i = 0; i < IN_FEAT; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      g_q     <= g_d;
      // Read data lands one cycle after the strobe; tag it with its k.
      rv_q    <= (state_q == MAC);
      rk_q    <= k_q;
      if (state_q == LOAD && x_valid) begin
        buf_q[k_q] <= x_data;
      end
    end
  end

  assign busy  = (state_q != IDLE);
  assign clr   = (state_q == IDLE) && start;
  assign y_idx = g_q;

  assign w_addr = (state_q == MAC) ?
                  (WAW'(g_q) * WAW'(IN_FEAT) + WAW'(k_q)) : '0;
  assign b_addr = (state_q == MAC && k_q == '0) ? g_q : '0;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fc_mac_lane #(
      .DATA_W(DATA_W),
      .FRAC_W(FRAC_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .en_i  (rv_q),
      .bias_i(rk_q == '0),
      .x_i   (buf_q[rk_q]),
      .w_i   (w_rdata[l*DATA_W +: DATA_W]),
      .b_i   (b_rdata[l*DATA_W +: DATA_W]),
      .y_o   (y_data[l*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench: a LANES=1 and a LANES=2 layer share one feature stream.
// Expected groups come from a plain-arithmetic neuron model.
module tb_fc_layer_seq;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, x_valid, y_ready;
  logic [15:0] x_data;

  logic busy1, x_ready1, w_rd_en1, y_valid1, done1;
  logic [2:0] w_addr1;
  logic [0:0] b_addr1, y_idx1;
  logic [15:0] w_rdata1, b_rdata1, y_data1;

  logic busy2, x_ready2, w_rd_en2, y_valid2, done2;
  logic [2:0] w_addr2;
  logic [0:0] b_addr2, y_idx2;
  logic [31:0] w_rdata2, b_rdata2, y_data2;

  logic signed [15:0] xv [3];
  logic signed [15:0] W1 [2][3];
  logic signed [15:0] B1 [2];
  logic signed [15:0] W2 [4][3];
  logic signed [15:0] B2 [4];

  exp_t q1[$];
  exp_t q2[$];
  int passed = 0;
  int total = 0;
  int dn1 = 0, dn2 = 0;
  int ac1 = 0, ac2 = 0;
  int yr_mode = 0;
  bit loading = 0;
  bit st1 = 0, st2 = 0;
  logic [16:0] sv1;
  logic [32:0] sv2;

  always #5 clk = ~clk;

  fc_layer_seq u_dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1),
    .x_valid(x_valid), .x_ready(x_ready1), .x_data(x_data),
    .w_rd_en(w_rd_en1), .w_addr(w_addr1), .w_rdata(w_rdata1),
    .b_addr(b_addr1), .b_rdata(b_rdata1),
    .y_valid(y_valid1), .y_ready(y_ready), .y_data(y_data1),
    .y_idx(y_idx1), .done(done1)
  );

  fc_layer_seq #(.OUT_FEAT(4), .LANES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .busy(busy2),
    .x_valid(x_valid), .x_ready(x_ready2), .x_data(x_data),
    .w_rd_en(w_rd_en2), .w_addr(w_addr2), .w_rdata(w_rdata2),
    .b_addr(b_addr2), .b_rdata(b_rdata2),
    .y_valid(y_valid2), .y_ready(y_ready), .y_data(y_data2),
    .y_idx(y_idx2), .done(done2)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Neuron value: bias scaled into Q format, dot product, round, clamp.
  function automatic logic [15:0] ref_n(input logic signed [15:0] b,
                                        input logic signed [15:0] w [3]);
    longint acc;
    longint r;
    acc = longint'(b) * 256;
    for (int k = 0; k < 3; k++) acc += longint'(xv[k]) * longint'(w[k]);
    r = (acc + 128) >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef FC_RELU_EN
    if (r < 0) r = 0;
`endif
    return 16'(r);
  endfunction

  // Synchronous weight/bias memories, one-cycle read latency.
  always @(posedge clk) begin
    int a, g, k, bg;
    if (w_rd_en1) begin
      a = int'(w_addr1); g = a / 3; k = a % 3; bg = int'(b_addr1);
      w_rdata1 <= W1[g][k];
      b_rdata1 <= B1[bg];
    end
    if (w_rd_en2) begin
      a = int'(w_addr2); g = a / 3; k = a % 3; bg = int'(b_addr2);
      w_rdata2 <= {W2[2*g+1][k], W2[2*g][k]};
      b_rdata2 <= {B2[2*bg+1], B2[2*bg]};
    end
  end

  // Output monitor: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q1.delete(); q2.delete(); st1 = 0; st2 = 0;
    end else begin
      if (done1) dn1++;
      if (done2) dn2++;
      if (!loading) chk("x_ready_outside_load", 64'({x_ready1, x_ready2}), 0);
      if (st1 && y_valid1) chk("y1_stable", 64'({y_idx1, y_data1}), 64'(sv1));
      if (st2 && y_valid2) chk("y2_stable", 64'({y_idx2, y_data2}), 64'(sv2));
      if (y_valid1 && y_ready) begin
        if (q1.size() == 0) chk("y1_unexpected_beat", 1, 0);
        else begin
          e = q1.pop_front();
          chk("y1_data", 64'(y_data1), 64'(e.data[15:0]));
          chk("y1_idx", 64'(y_idx1), 64'(e.idx));
        end
      end
      if (y_valid2 && y_ready) begin
        if (q2.size() == 0) chk("y2_unexpected_beat", 1, 0);
        else begin
          e = q2.pop_front();
          chk("y2_data", 64'(y_data2), 64'(e.data));
          chk("y2_idx", 64'(y_idx2), 64'(e.idx));
        end
      end
      st1 = y_valid1 && !y_ready; sv1 = {y_idx1, y_data1};
      st2 = y_valid2 && !y_ready; sv2 = {y_idx2, y_data2};
    end
  end

  // Read address sequence: g*IN_FEAT+k, bias address g on each k==0 read.
  always @(negedge clk) begin
    if (rst) begin
      ac1 = 0; ac2 = 0;
    end else begin
      if (w_rd_en1) begin
        chk("w_addr1", 64'(w_addr1), 64'(ac1));
        if (ac1 % 3 == 0) chk("b_addr1", 64'(b_addr1), 64'(ac1 / 3));
        ac1 = (ac1 + 1) % 6;
      end
      if (w_rd_en2) begin
        chk("w_addr2", 64'(w_addr2), 64'(ac2));
        if (ac2 % 3 == 0) chk("b_addr2", 64'(b_addr2), 64'(ac2 / 3));
        ac2 = (ac2 + 1) % 6;
      end
    end
  end

  // Downstream ready: always, random, or a 20-cycle stall per result.
  initial begin
    int hold;
    bit anyv;
    hold = 0;
    y_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      anyv = y_valid1 || y_valid2;
      if (!anyv) hold = 0;
      case (yr_mode)
        1: y_ready = 1'($urandom_range(1));
        2: y_ready = (hold >= 20);
        default: y_ready = 1'b1;
      endcase
      if (anyv && !y_ready) hold++;
    end
  end

  task automatic push_exp();
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      e.idx = g;
      e.data = {16'h0, ref_n(B1[g], W1[g])};
      q1.push_back(e);
      e.data = {ref_n(B2[2*g+1], W2[2*g+1]), ref_n(B2[2*g], W2[2*g])};
      q2.push_back(e);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_ctl1", 64'({busy1, x_ready1, w_rd_en1, y_valid1, done1}), 0);
    chk("rst_dat1", 64'({y_data1, y_idx1, w_addr1, b_addr1}), 0);
    chk("rst_ctl2", 64'({busy2, x_ready2, w_rd_en2, y_valid2, done2}), 0);
    chk("rst_dat2", 64'({y_data2, y_idx2, w_addr2, b_addr2}), 0);
  endtask

  task automatic begin_vec();
    @(negedge clk); loading = 1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic load_x(input bit gaps);
    int k, n;
    bit rdy;
    k = 0; n = 0;
    while (k < 3 && n < 200) begin
      @(negedge clk);
      rdy = x_ready1;
      if (gaps && $urandom_range(2) == 0) x_valid = 0;
      else begin
        x_valid = 1; x_data = xv[k];
      end
      @(posedge clk);
      if (x_valid && rdy) k++;
      n++;
    end
    loading = 0;
    #1 x_valid = 0;
    chk("load_beats", 64'(k), 3);
  endtask

  task automatic run_vec(input bit gaps, input bit spur);
    int b1, b2, n;
    push_exp();
    b1 = dn1; b2 = dn2;
    begin_vec();
    load_x(gaps);
    if (spur) begin
      @(negedge clk); start = 1; x_valid = 1; x_data = 16'hDEAD;
      @(negedge clk); start = 0; x_valid = 0;
    end
    n = 0;
    while (!(dn1 > b1 && dn2 > b2) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("done_timeout", 64'(n >= 3000), 0);
    repeat (4) @(negedge clk);
    chk("done1_once", 64'(dn1 - b1), 1);
    chk("done2_once", 64'(dn2 - b2), 1);
    chk("q_drained", 64'(q1.size() + q2.size()), 0);
    chk("idle_after", 64'({busy1, busy2}), 0);
  endtask

  function automatic logic signed [15:0] rnd(input bit big);
    if (big) return 16'($urandom);
    return 16'(int'($urandom_range(0, 2047)) - 1024);
  endfunction

  task automatic fill_rand(input bit big);
    for (int k = 0; k < 3; k++) begin
      xv[k] = rnd(big);
      for (int n = 0; n < 2; n++) W1[n][k] = rnd(big);
      for (int n = 0; n < 4; n++) W2[n][k] = rnd(big);
    end
    for (int n = 0; n < 2; n++) B1[n] = rnd(big);
    for (int n = 0; n < 4; n++) B2[n] = rnd(big);
  endtask

  task automatic fill_const(input logic signed [15:0] xc,
                            input logic signed [15:0] wc,
                            input logic signed [15:0] bc);
    for (int k = 0; k < 3; k++) begin
      xv[k] = xc;
      for (int n = 0; n < 2; n++) W1[n][k] = wc;
      for (int n = 0; n < 4; n++) W2[n][k] = wc;
    end
    for (int n = 0; n < 2; n++) B1[n] = bc;
    for (int n = 0; n < 4; n++) B2[n] = bc;
  endtask

  task automatic set_nom();
    fill_rand(0);
    xv[0] = 16'h0100; xv[1] = 16'h0200; xv[2] = 16'h0300;
    for (int k = 0; k < 3; k++) W1[0][k] = 16'h0100;
    B1[0] = 16'h0080;
    W1[1][0] = 16'h0080; W1[1][1] = 0; W1[1][2] = 0;
    B1[1] = 0;
    for (int k = 0; k < 3; k++) begin
      W2[0][k] = W1[0][k]; W2[1][k] = W1[1][k];
    end
    B2[0] = B1[0]; B2[1] = B1[1];
  endtask

  initial begin
    rst = 1; start = 0; x_valid = 0; x_data = 0;
    fill_const(0, 0, 0);
    repeat (3) @(negedge clk);
    chk_reset_outs();
    rst = 0;

    set_nom();
    run_vec(0, 0);

    fill_rand(0);
    xv[0] = 16'h0100; xv[1] = 0; xv[2] = 0;
    W1[0][0] = 16'hFE00; B1[0] = 0;
    W2[0][0] = 16'hFE00; B2[0] = 0;
    run_vec(0, 0);

    fill_const(16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_vec(0, 0);
    fill_const(16'h7FFF, 16'h8000, 16'h8000);
    run_vec(0, 0);

    set_nom();
    yr_mode = 2;
    run_vec(1, 0);
    yr_mode = 0;

    fill_rand(0);
    push_exp();
    begin_vec();
    load_x(0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_reset_outs();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    repeat (12) @(negedge clk);
    chk("no_beat_after_rst", 64'({busy1, busy2, y_valid1, y_valid2}), 0);

    set_nom();
    run_vec(1, 1);

    yr_mode = 1;
    for (int i = 0; i < 6; i++) begin
      fill_rand(i[0]);
      run_vec(1, i[1]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
Time-multiplexed fully connected layer, the parametrised successor of the combinational matmul+matadd datapath.
- Buffers one input feature vector, then computes LANES output neurons per pass with signed fixed-point multiply-accumulate against an external synchronous weight/bias memory.
- Emits each output group through a valid/ready handshake and pulses done at the end of the vector.
- Sits between the feature stream and the next layer or activation stage.

Parameters:
DATA_W, 16, signed two's-complement width of features, weights, bias and results
FRAC_W, 8, fractional bits of the shared Q format
ACC_W, 40, accumulator width; must be >= 2*DATA_W + clog2(IN_FEAT)
IN_FEAT, 3, input features per vector
OUT_FEAT, 2, output neurons; OUT_FEAT % LANES == 0
LANES, 1, neurons computed in parallel per pass

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  begin a vector; sampled in IDLE only
busy  out  1  high in every state except IDLE
x_valid  in  1  feature beat valid
x_ready  out  1  high only in LOAD
x_data  in  DATA_W  feature k, in order k=0..IN_FEAT-1
w_rd_en  out  1  weight/bias read strobe
w_addr  out  clog2(OUT_FEAT/LANES*IN_FEAT)  = g*IN_FEAT + k
w_rdata  in  LANES*DATA_W  lane l weight, valid 1 cycle after w_rd_en
b_addr  out  clog2(OUT_FEAT/LANES)  = g, driven with k==0 read
b_rdata  in  LANES*DATA_W  lane l bias, same 1-cycle latency
y_valid  out  1  result group valid
y_ready  in  1  downstream accept
y_data  out  LANES*DATA_W  lane l = neuron g*LANES+l
y_idx  out  clog2(OUT_FEAT/LANES)  group index g
done  out  1  one-cycle pulse after the last group is accepted

Behaviour:
- Reset: state IDLE. busy, x_ready, w_rd_en, y_valid and done are 0. y_data, y_idx, w_addr and b_addr are 0. Accumulators and feature buffer are cleared. rst mid-operation aborts immediately with no further y beats.
- IDLE: start=1 -> LOAD, k=0. Otherwise stay.
- LOAD: x_ready=1. Each x_valid cycle stores x_data into buf[k] and increments k. After beat IN_FEAT-1 go to MAC with g=0, k=0. Minimum LOAD time is IN_FEAT cycles.
- MAC: one read per cycle with w_rd_en=1 and k=0..IN_FEAT-1, IN_FEAT cycles. Data returns one cycle later.
  - At the k=0 return, acc_l = sext(b_l) <<< FRAC_W, plus buf[0]*w_l.
  - Later returns do acc_l += buf[k]*w_l, with the full 2*DATA_W product sign-extended to ACC_W.
  - After the last read go to DRAIN.
- DRAIN: one cycle absorbing the final read return, then OUT.
- OUT: y_valid=1; y_data holds the rounded and saturated accumulators; y_idx=g.
  - y_data and y_idx are stable while y_ready=0; the stall is unbounded.
  - On y_valid&&y_ready: if g < OUT_FEAT/LANES-1 then g++ and go to MAC; else go to DONE.
- DONE: done=1 for one cycle -> IDLE. start in this same cycle is ignored.
- Per-group latency from MAC entry to y_valid: IN_FEAT+1 cycles.
- Output arithmetic:
  - r = acc >>> FRAC_W, round-half-up: add 1<<(FRAC_W-1) before the shift.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Accumulator overflow cannot occur given the ACC_W constraint; add an elaboration-time check of that constraint and of OUT_FEAT%LANES.
- start while busy is ignored.
- x_valid outside LOAD is ignored (x_ready=0).
- IN_FEAT=1: MAC is a single cycle and bias plus product are applied in the same update.

Optional Feature:
FC_RELU_EN
- Defined: after saturation, negative lane results are forced to 0 before y_data.
- Undefined: signed results pass through unchanged.
- Timing and handshake are identical in both builds.

Decomposition:
- Package fc_pkg holds:
  - state enum (IDLE, LOAD, MAC, DRAIN, OUT, DONE);
  - function sat_round(acc, FRAC_W, DATA_W);
  - localparam helpers for group count and address widths.
- One sub-module, fc_mac_lane: a single-lane accumulator with clear/load-bias/accumulate controls and a rounded+saturated output.
- The top instantiates LANES copies of fc_mac_lane and owns the FSM and buffer.

Test Plan:
1. Nominal run (DATA_W=16, FRAC_W=8, LANES=1):
   - Stimulus: x={0x0100,0x0200,0x0300}; row0 w={0x0100,0x0100,0x0100}, b0=0x0080; row1 w={0x0080,0,0}, b1=0.
   - Required: y_idx0 y_data=0x0680; y_idx1 y_data=0x0080; done pulses once.
2. Negative result:
   - Stimulus: x={0x0100,0,0}, w0={0xFE00,...}, b0=0.
   - Required: y_data=0xFE00 without FC_RELU_EN; 0x0000 with it.
3. Saturation:
   - Stimulus: all x=0x7FFF, all w=0x7FFF, b=0x7FFF.
   - Required: y_data=0x7FFF. The all-negative mirror gives 0x8000.
4. Backpressure:
   - Stimulus: hold y_ready=0 for 20 cycles in OUT, with x_valid gaps during LOAD.
   - Required: y_data/y_idx stable, x_ready=0 outside LOAD, results equal to scenario 1.
5. LANES=2, OUT_FEAT=4:
   - Stimulus: same x as scenario 1.
   - Required: 2 groups; w_addr sequence 0,1,2,3,4,5; b_addr 0 then 1; lane packing is correct.
6. Reset and spurious start:
   - Stimulus: assert rst during MAC of group 0, then pulse start while busy.
   - Required: immediate IDLE with all outputs 0 and no y beat; start while busy is ignored; a fresh start completes normally.
